// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and response handshake bundle
// between the datapath (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory over a 64-bit RAM, one request at a time
module data_mem_responder #(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input logic                 clock,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        a_write, a_write_n;
  logic [63:0] a_addr, a_addr_n;
  logic [1:0]  a_size, a_size_n;
  logic [63:0] a_wdata, a_wdata_n;
  logic        ready_q, ready_n;
  logic        valid_q, valid_n;
  logic [63:0] rdata_q, rdata_n;
  logic        err_q, err_n;
  logic        commit;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic          oor, mis, err;
  logic [2:0]    lane, smask;
  logic [7:0]    szb, be;
  logic [63:0]   bm, dm, old, wnew, ld;
  assign widx  = a_addr[AW+2:3];
  assign oor   = |a_addr[63:AW+3];
  assign smask = {a_size == 2'd3, a_size[1], |a_size};
  assign szb   = a_size == 2'd0 ? 8'h01 : a_size == 2'd1 ? 8'h03 : a_size == 2'd2 ? 8'h0F : 8'hFF;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign lane = a_addr[2:0];
  assign mis  = |(a_addr[2:0] & smask);
`else
  assign lane = a_addr[2:0] & ~smask;
  assign mis  = 1'b0;
`endif
  assign err = oor | mis;
  assign be  = szb << lane;
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign bm[8*i +: 8] = {8{be[i]}};
    assign dm[8*i +: 8] = {8{szb[i]}};
  end
  assign old  = mem[widx];
  assign wnew = (old & ~bm) | ((a_wdata << {lane, 3'b000}) & bm);
  assign ld   = (old >> {lane, 3'b000}) & dm;
  always_ff @(posedge clock)
    if (commit && a_write && !err) mem[widx] <= wnew;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_write <= 1'b0;
      a_addr  <= '0;
      a_size  <= '0;
      a_wdata <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_write <= a_write_n;
      a_addr  <= a_addr_n;
      a_size  <= a_size_n;
      a_wdata <= a_wdata_n;
      ready_q <= ready_n;
      valid_q <= valid_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    a_write_n = a_write;
    a_addr_n  = a_addr;
    a_size_n  = a_size;
    a_wdata_n = a_wdata;
    ready_n   = ready_q;
    valid_n   = valid_q;
    rdata_n   = rdata_q;
    err_n     = err_q;
    commit    = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        a_write_n = bus.req_write;
        a_addr_n  = bus.req_addr;
        a_size_n  = bus.req_size;
        a_wdata_n = bus.req_wdata;
        cnt_n     = LAT_M1;
        ready_n   = 1'b0;
        state_n   = BUSY;
      end
      BUSY: if (cnt == 4'd0) begin
        commit  = 1'b1;
        valid_n = 1'b1;
        err_n   = err;
        rdata_n = (err || a_write) ? 64'd0 : ld;
        state_n = DONE;
      end else begin
        cnt_n = cnt - 4'd1;
      end
      DONE: if (bus.resp_ready) begin
        valid_n = 1'b0;
        rdata_n = '0;
        err_n   = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule
